// File: rtl/mr_operand_mul.sv
// mr_operand_mul: 3-stage Kyber/Dilithium coefficient multiplier feeding Montgomery reduction,
// with valid/ready flow control, a mode-switch interlock and a sticky operand range flag.
module mr_operand_mul #(
  parameter int QK  = 3329,
  parameter int QD  = 8380417,
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode_in,
  input  logic [22:0] a,
  input  logic [22:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [45:0] d,
  output logic        mode_out,
  output logic        range_err,
  input  logic        clr_err,
  output logic        busy
);
  localparam logic [22:0] QK23 = 23'(QK);
  localparam logic [22:0] QD23 = 23'(QD);
  if (LAT != 3) begin : g_lat
    $error("mr_operand_mul supports only LAT=3");
  end
  logic        v1, v2, m1, m2, last_mode, stall, accept, bad;
  logic [22:0] a1, b1;
  logic [21:0] pp_hh;
  logic [22:0] pp_hl, pp_lh;
  logic [23:0] pp_ll;
  logic [45:0] sum;
  assign busy     = v1 | v2 | out_valid;
  assign stall    = out_valid & ~out_ready;
  // a mode change must wait until every product of the old mode has left
  assign in_ready = ~rst & ~stall & ~(in_valid & (mode_in != last_mode) & busy);
  assign accept   = in_valid & in_ready;
  assign bad      = mode_in ? (a >= QD23 || b >= QD23) : (a >= QK23 || b >= QK23);
  assign sum      = (46'(pp_hh) << 24) + (46'(pp_hl) << 12) + (46'(pp_lh) << 12) + 46'(pp_ll);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      m1 <= 1'b0;
      m2 <= 1'b0;
      pp_hh <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_ll <= '0;
      d <= '0;
      mode_out <= 1'b0;
      last_mode <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (!stall) begin
        v1 <= accept;
        v2 <= v1;
        out_valid <= v2;
        if (accept) begin
          a1 <= a;
          b1 <= b;
          m1 <= mode_in;
        end
        if (v1) begin
          pp_hh <= 22'(a1[22:12]) * 22'(b1[22:12]);
          pp_hl <= 23'(a1[22:12]) * 23'(b1[11:0]);
          pp_lh <= 23'(a1[11:0]) * 23'(b1[22:12]);
          pp_ll <= 24'(a1[11:0]) * 24'(b1[11:0]);
          m2 <= m1;
        end
        if (v2) begin
          d <= sum;
          mode_out <= m2;
        end
      end
      if (accept) last_mode <= mode_in;
      range_err <= (accept & bad) | (range_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_mr_operand_mul.sv
// tb_mr_operand_mul: directed + randomized check of mr_operand_mul against a queue-based model.
module tb_mr_operand_mul;
  localparam int QK = 3329;
  localparam int QD = 8380417;
  logic        clk = 1'b0;
  logic        rst, in_valid, mode_in, out_ready, clr_err;
  logic [22:0] a, b;
  logic        in_ready, out_valid, mode_out, range_err, busy;
  logic [45:0] d;
  typedef struct {
    logic [45:0] p;
    logic        m;
    int          age;
  } ent_t;
  ent_t q[$];
  logic rerr_m, lmode_m, acc_m, prev_ov, prev_m;
  int   total = 0;
  int   bad_n = 0;

  mr_operand_mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode_in(mode_in),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .d(d), .mode_out(mode_out),
    .range_err(range_err), .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Entries age one step per unstalled edge; age 3 at the head means it is on the output.
  task automatic step();
    logic ov, bsy, st, rdy, badop;
    ent_t e;
    #1;
    bsy = q.size() > 0;
    ov  = bsy && q[0].age == 3;
    st  = ov && !out_ready;
    rdy = !st && !(in_valid && mode_in != lmode_m && bsy);
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, rdy);
    chk("busy", busy, bsy);
    chk("range_err", range_err, rerr_m);
    if (ov) begin
      chk("d", d, q[0].p);
      chk("mode_out", mode_out, q[0].m);
    end
    if (out_valid && prev_ov) chk("mode_adj", mode_out, prev_m);
    prev_ov = out_valid;
    prev_m  = mode_out;
    acc_m = in_valid && rdy;
    if (ov && out_ready) void'(q.pop_front());
    if (!st) foreach (q[i]) q[i].age++;
    if (acc_m) begin
      e.p = 46'(a) * 46'(b);
      e.m = mode_in;
      e.age = 1;
      q.push_back(e);
      lmode_m = mode_in;
    end
    badop = mode_in ? (a >= QD || b >= QD)
                    : (a >= QK || b >= QK || a[22:12] != 0 || b[22:12] != 0);
    if (acc_m && badop) rerr_m = 1'b1;
    else if (clr_err) rerr_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic m, input int aa, input int bb, output int tries);
    in_valid = 1'b1;
    mode_in = m;
    a = 23'(aa);
    b = 23'(bb);
    tries = 0;
    acc_m = 1'b0;
    while (!acc_m && tries < 20) begin
      step();
      tries++;
    end
    if (!acc_m) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; mode_in = 1'b0; a = '0; b = '0;
    out_ready = 1'b1; clr_err = 1'b0;
    rerr_m = 1'b0; lmode_m = 1'b0; prev_ov = 1'b0; prev_m = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_mode_out", mode_out, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    // single Kyber product at the top of the range
    send(1'b0, 3328, 3328, t);
    idle(3);
    chk("kyber_max_d", d, 46'd11075584);
    // Dilithium max product held on the output for several stalled cycles
    out_ready = 1'b0;
    send(1'b1, 8380416, 8380416, t);
    idle(2);
    in_valid = 1'b1; mode_in = 1'b1; a = 23'd7; b = 23'd9;
    repeat (6) step();
    chk("dil_max_d", d, 46'd70231372333056);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    // back-to-back Kyber stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      mode_in = 1'b0;
      a = (i == 0) ? 23'd1234 : 23'($urandom_range(0, QK - 1));
      b = (i == 0) ? 23'd5678 : 23'($urandom_range(0, QK - 1));
      if (i == 3) begin
        #1;
        chk("stream_first_d", d, 46'd7006652);
      end
      step();
    end
    idle(4);
    // mode interlock: Dilithium waits for the Kyber product to leave
    send(1'b0, 100, 200, t);
    send(1'b1, 300, 400, t);
    chk("interlock_tries", t, 4);
    idle(4);
    // range flag set, cleared, and set-wins-over-clear
    send(1'b0, 3329, 1, t);
    idle(3);
    chk("range_d", d, 46'd3329);
    chk("range_set", range_err, 1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("range_clr", range_err, 0);
    clr_err = 1'b1;
    send(1'b0, 4096, 5, t);
    clr_err = 1'b0;
    chk("range_set_wins", range_err, 1);
    idle(4);
    // reset with three entries in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; mode_in = 1'b0; a = 23'(i + 11); b = 23'(i + 13);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_d", d, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    rerr_m = 1'b0; lmode_m = 1'b0; prev_ov = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) mode_in = ~mode_in;
      if (mode_in) begin
        a = 23'(($urandom_range(0, 19) == 0) ? $urandom_range(QD, 8388607) : $urandom_range(0, QD - 1));
        b = 23'(($urandom_range(0, 19) == 0) ? $urandom_range(QD, 8388607) : $urandom_range(0, QD - 1));
      end else begin
        a = 23'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 8388607) : $urandom_range(0, QK - 1));
        b = 23'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 8388607) : $urandom_range(0, QK - 1));
      end
      out_ready = $urandom_range(0, 3) != 0;
      clr_err = $urandom_range(0, 9) == 0;
      step();
    end
    clr_err = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end
endmodule
